// File: rtl/fpadd_arb_pkg.sv
// Shared types and default sizing for the floating-point adder arbiter.
package fpadd_arb_pkg;

    localparam int unsigned NREQ_DEF    = 4;
    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ArbState;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: searches upward from last_i+1 (mod NREQ)
// and returns the first active request as one-hot grant and index.
module rr_picker #(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]         req_i,
    input  logic [$clog2(NREQ)-1:0] last_i,
    output logic [NREQ-1:0]         grant_o,
    output logic [$clog2(NREQ)-1:0] grant_idx_o,
    output logic                    any_o
);

    localparam int unsigned IdW = $clog2(NREQ);

    logic [IdW-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        idx         = '0;
        // k = NREQ wraps back to last_i itself, so it has the lowest priority.
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = IdW'((32'(last_i) + k) % NREQ);
            if (!any_o && req_i[idx]) begin
                any_o       = 1'b1;
                grant_idx_o = idx;
            end
        end
        if (any_o) begin
            grant_o[grant_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fpadd_arbiter.sv
// Round-robin sequencer sharing one FP adder among NREQ requesters, with a
// watchdog on the adder's completion flag.
module fpadd_arbiter
    import fpadd_arb_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ*WIDTH-1:0]   req_a_i,
    input  logic [NREQ*WIDTH-1:0]   req_b_i,
    output logic [NREQ-1:0]         req_accept_o,
    output logic                    add_go_o,
    output logic [WIDTH-1:0]        add_a_o,
    output logic [WIDTH-1:0]        add_b_o,
    input  logic                    add_ready_i,
    input  logic [WIDTH-1:0]        add_result_i,
    output logic                    resp_valid_o,
    output logic [$clog2(NREQ)-1:0] resp_id_o,
    output logic [WIDTH-1:0]        resp_data_o,
    output logic                    resp_error_o,
    output logic                    busy_o
);

    localparam int unsigned IdW  = $clog2(NREQ);
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    ArbState          state_q, state_d;
    logic [IdW-1:0]   last_q, last_d;
    logic [IdW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic [NREQ-1:0]  grant;
    logic [IdW-1:0]   grant_idx;
    logic             grant_any;

    rr_picker #(
        .NREQ(NREQ)
    ) u_picker (
        .req_i      (req_valid_i),
        .last_i     (last_q),
        .grant_o    (grant),
        .grant_idx_o(grant_idx),
        .any_o      (grant_any)
    );

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_any) begin
                    a_d     = req_a_i[32'(grant_idx)*WIDTH +: WIDTH];
                    b_d     = req_b_i[32'(grant_idx)*WIDTH +: WIDTH];
                    id_d    = grant_idx;
                    last_d  = grant_idx;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ready wins over the watchdog when both land in the same cycle.
                if (add_ready_i) begin
                    res_d   = add_result_i;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (cnt_q == CntLast) begin
                    res_d   = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            last_q  <= IdW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        req_accept_o = (state_q == IDLE) ? grant : '0;
        add_go_o     = (state_q == ISSUE);
        add_a_o      = a_q;
        add_b_o      = b_q;
        busy_o       = (state_q != IDLE);
        resp_valid_o = (state_q == RESP);
        resp_id_o    = resp_valid_o ? id_q : '0;
        resp_data_o  = resp_valid_o ? res_q : '0;
        resp_error_o = resp_valid_o & err_q;
    end

endmodule

// File: tb/tb_fpadd_arbiter.sv
// Randomized bench for fpadd_arbiter: transaction-level reference model plus a
// behavioural adder with programmable latency.
module tb_fpadd_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 32;
    localparam int TIMEOUT = 16;
    localparam int NEVER   = TIMEOUT + 1000;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req_valid = '0;
    logic [NREQ*WIDTH-1:0] req_a = '0;
    logic [NREQ*WIDTH-1:0] req_b = '0;
    logic [NREQ-1:0]       req_accept;
    logic                  add_go;
    logic [WIDTH-1:0]      add_a, add_b;
    logic                  add_ready;
    logic [WIDTH-1:0]      add_result;
    logic                  resp_valid;
    logic [1:0]            resp_id;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_error;
    logic                  busy;

    always #5 clk = ~clk;

    fpadd_arbiter #(
        .NREQ   (NREQ),
        .WIDTH  (WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_valid_i (req_valid),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_accept_o(req_accept),
        .add_go_o    (add_go),
        .add_a_o     (add_a),
        .add_b_o     (add_b),
        .add_ready_i (add_ready),
        .add_result_i(add_result),
        .resp_valid_o(resp_valid),
        .resp_id_o   (resp_id),
        .resp_data_o (resp_data),
        .resp_error_o(resp_error),
        .busy_o      (busy)
    );

    // Float helpers for operands that are small integers (exact in both formats).
    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        int e;
        if (f[30:23] == 8'd0) return 0.0;
        e = int'(f[30:23]) - 127 + 1023;
        d = {f[31], e[10:0], f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        int e;
        if (r == 0.0) return 32'h0;
        d = $realtobits(r);
        e = int'(d[62:52]) - 1023 + 127;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_f();
        int v;
        v = int'($urandom_range(200)) - 100;
        return r2f(real'(v));
    endfunction

    // Behavioural adder: Ready clears when Go is sampled, rises lat_next cycles
    // after the Go cycle.
    int lat_next = 2;
    int stub_rem;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_ready  <= 1'b0;
            add_result <= '0;
            stub_rem   <= 0;
        end else if (add_go) begin
            add_ready <= 1'b0;
            stub_rem  <= lat_next - 1;
        end else if (stub_rem > 0) begin
            stub_rem <= stub_rem - 1;
            if (stub_rem == 1) begin
                add_ready  <= 1'b1;
                add_result <= fadd(add_a, add_b);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_grant(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    // Reference model state (one transaction in flight at most).
    int          cyc = 0;
    bit          m_busy = 0;
    int          m_id, m_go, m_resp;
    int          m_last = NREQ - 1;
    logic [31:0] m_a = '0, m_b = '0, m_data;
    bit          m_err;

    // Stimulus control and DUT observations for the directed checks.
    int          mode = 0;       // 0 manual, 1 random requesters, 2 all requesting
    int          lat_fix = 0;    // 0 -> random latency
    int          grant_log[$];
    int          acc1 = 0, resp_cnt = 0;
    int          d_acc_cyc, d_go_cyc, d_resp_cyc;
    logic [3:0]  d_acc_val;
    logic [1:0]  d_resp_id;
    logic [31:0] d_resp_data;
    logic        d_resp_err;

    function automatic int pick_lat();
        int r;
        if (lat_fix != 0) return lat_fix;
        r = int'($urandom_range(99));
        if (r < 70) return int'($urandom_range(10, 2));
        if (r < 85) return TIMEOUT;
        return NEVER;
    endfunction

    task automatic new_req(input int i);
        req_valid[i] = 1'b1;
        req_a[i*WIDTH +: WIDTH] = rand_f();
        req_b[i*WIDTH +: WIDTH] = rand_f();
    endtask

    task automatic tick();
        int g, lat, acc;
        acc = -1;
        @(negedge clk);
        cyc++;
        if (|req_accept) begin
            d_acc_val = req_accept;
            d_acc_cyc = cyc;
            for (int i = 0; i < NREQ; i++) if (req_accept[i]) grant_log.push_back(i);
            if (req_accept[1]) acc1++;
        end
        if (add_go) d_go_cyc = cyc;
        if (resp_valid) begin
            d_resp_cyc  = cyc;
            d_resp_id   = resp_id;
            d_resp_data = resp_data;
            d_resp_err  = resp_error;
            resp_cnt++;
        end
        if (!rst_n) begin
            chk("rst_accept", 64'(req_accept), 64'(0));
            chk("rst_go", 64'(add_go), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
            chk("rst_resp_valid", 64'(resp_valid), 64'(0));
            chk("rst_add_a", 64'(add_a), 64'(0));
            chk("rst_add_b", 64'(add_b), 64'(0));
            m_busy = 0;
            m_last = NREQ - 1;
            m_a    = '0;
            m_b    = '0;
        end else begin
            g = m_busy ? -1 : exp_grant(req_valid, m_last);
            chk("accept", 64'(req_accept), (g < 0) ? 64'(0) : (64'(1) << g));
            chk("go", 64'(add_go), 64'(m_busy && cyc == m_go));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("resp_valid", 64'(resp_valid), 64'(m_busy && cyc == m_resp));
            if (m_busy && cyc == m_resp) begin
                chk("resp_id", 64'(resp_id), 64'(m_id));
                chk("resp_data", 64'(resp_data), 64'(m_data));
                chk("resp_error", 64'(resp_error), 64'(m_err));
            end
            chk("add_a", 64'(add_a), 64'(m_a));
            chk("add_b", 64'(add_b), 64'(m_b));
            if (m_busy && cyc == m_resp) begin
                m_busy = 0;
            end else if (g >= 0) begin
                lat      = pick_lat();
                lat_next = lat;
                m_busy   = 1;
                m_id     = g;
                m_last   = g;
                m_a      = req_a[g*WIDTH +: WIDTH];
                m_b      = req_b[g*WIDTH +: WIDTH];
                m_go     = cyc + 1;
                m_resp   = m_go + ((lat < TIMEOUT) ? lat : TIMEOUT) + 1;
                m_err    = (lat > TIMEOUT);
                m_data   = m_err ? 32'h0 : fadd(m_a, m_b);
                acc      = g;
            end
        end
        @(posedge clk);
        #1;
        if (acc >= 0) req_valid[acc] = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] && (mode == 2 || (mode == 1 && $urandom_range(3) == 0)))
                new_req(i);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int bound;

    initial begin
        #2 rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(2);

        chk("model_fadd_1_2", 64'(fadd(32'h3F800000, 32'h40000000)), 64'h40400000);

        // Fairness: everybody requesting, first grant goes to requester 0.
        grant_log.delete();
        mode = 2;
        bound = 0;
        while (grant_log.size() < 8 && bound < 600) begin
            tick();
            bound++;
        end
        mode = 0;
        req_valid = '0;
        chk("fair_grant_count", 64'(grant_log.size() >= 8), 64'(1));
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk($sformatf("fair_order_%0d", i), 64'(grant_log[i]), 64'(i % 4));
        run(TIMEOUT + 4);

        // Single request from requester 2: 1.0 + 2.0.
        lat_fix = 3;
        req_a[2*WIDTH +: WIDTH] = 32'h3F800000;
        req_b[2*WIDTH +: WIDTH] = 32'h40000000;
        req_valid[2] = 1'b1;
        run(8);
        chk("single_accept", 64'(d_acc_val), 64'h4);
        chk("single_go_lat", 64'(d_go_cyc - d_acc_cyc), 64'(1));
        chk("single_resp_lat", 64'(d_resp_cyc - d_go_cyc), 64'(4));
        chk("single_id", 64'(d_resp_id), 64'(2));
        chk("single_data", 64'(d_resp_data), 64'h40400000);
        chk("single_err", 64'(d_resp_err), 64'(0));

        // Adder never completes.
        lat_fix = NEVER;
        new_req(0);
        run(TIMEOUT + 6);
        chk("timeout_lat", 64'(d_resp_cyc - d_go_cyc), 64'(TIMEOUT + 1));
        chk("timeout_err", 64'(d_resp_err), 64'(1));
        chk("timeout_data", 64'(d_resp_data), 64'(0));

        // Ready arrives in the same cycle the watchdog expires: 5.0 + 7.0.
        lat_fix = TIMEOUT;
        req_a[1*WIDTH +: WIDTH] = 32'h40A00000;
        req_b[1*WIDTH +: WIDTH] = 32'h40E00000;
        req_valid[1] = 1'b1;
        run(TIMEOUT + 6);
        chk("race_lat", 64'(d_resp_cyc - d_go_cyc), 64'(TIMEOUT + 1));
        chk("race_err", 64'(d_resp_err), 64'(0));
        chk("race_data", 64'(d_resp_data), 64'h41400000);

        // Requester 1 raises and withdraws while the arbiter is busy.
        lat_fix = 10;
        acc1 = 0;
        resp_cnt = 0;
        new_req(3);
        run(2);
        new_req(1);
        run(4);
        req_valid[1] = 1'b0;
        run(16);
        chk("withdraw_no_accept", 64'(acc1), 64'(0));
        chk("withdraw_resp_count", 64'(resp_cnt), 64'(1));
        chk("withdraw_resp_id", 64'(d_resp_id), 64'(3));

        // Reset while waiting on the adder.
        lat_fix = 12;
        new_req(2);
        run(5);
        chk("prereset_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("reset_now_busy", 64'(busy), 64'(0));
        chk("reset_now_go", 64'(add_go), 64'(0));
        chk("reset_now_add_a", 64'(add_a), 64'(0));
        chk("reset_now_resp", 64'(resp_valid), 64'(0));
        resp_cnt = 0;
        run(2);
        rst_n = 1'b1;
        lat_fix = 0;
        grant_log.delete();
        mode = 2;
        bound = 0;
        while (grant_log.size() < 1 && bound < 50) begin
            tick();
            bound++;
        end
        chk("postreset_grant_seen", 64'(grant_log.size() >= 1), 64'(1));
        if (grant_log.size() >= 1) chk("postreset_first_grant", 64'(grant_log[0]), 64'(0));
        chk("postreset_no_stale_resp", 64'(resp_cnt), 64'(0));

        // Random traffic.
        mode = 1;
        run(1500);
        mode = 0;
        req_valid = '0;
        run(TIMEOUT + 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fpadd_arbiter.md
# fpadd_arbiter

Round-robin arbiter and sequencer that shares one single-precision floating-point adder among NREQ requesters. It accepts one operand pair at a time, drives the adder's Go/Ready handshake, and returns the sum tagged with the requester ID. A watchdog bounds the wait for the adder's completion. It sits between the requesting units and the adder top module.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- WIDTH, 32, operand/result width (sign + 8 exp + 23 mantissa)
- TIMEOUT, 64, maximum cycles in WAIT before an error response (>= 8)

Ports:
- Clock  in  1  single clock, rising edge
- ResetN  in  1  asynchronous, active-low reset
- ReqValid  in  NREQ  per-requester request; held high until accepted
- ReqA  in  NREQ*WIDTH  operand A, slice i belongs to requester i
- ReqB  in  NREQ*WIDTH  operand B, slice i belongs to requester i
- ReqAccept  out  NREQ  one-hot, one-cycle pulse; operands sampled this cycle
- AddGo  out  1  start pulse to adder
- AddA, AddB  out  WIDTH  operands to adder, held stable ISSUE..RESP
- AddReady  in  1  adder level done flag; cleared by adder on sampled Go
- AddResult  in  WIDTH  adder sum, valid while AddReady=1
- RespValid  out  1  one-cycle response pulse
- RespId  out  $clog2(NREQ)  requester that owns the response
- RespData  out  WIDTH  sum (0 on error)
- RespError  out  1  timeout flag, qualified by RespValid
- Busy  out  1  high in any state except IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any ReqValid is high, pick the winner by round-robin, starting at (Last+1) mod NREQ. ReqAccept[g]=1 combinationally in this cycle. At the clock edge: latch ReqA/ReqB slice g into the operand registers, set Id=g and Last=g, then go to ISSUE. With no request, stay in IDLE.
- ISSUE: AddGo=1 for exactly one cycle; clear the watchdog count; go to WAIT.
- WAIT: increment the count each cycle.
  - If AddReady=1: latch AddResult, clear Err, go to RESP.
  - Else if count == TIMEOUT-1: latch 0, set Err, go to RESP.
  - AddReady has priority when both conditions are true in the same cycle.
- RESP: drive RespValid=1, RespId=Id, RespData and RespError from the latches; go to IDLE.
- The response has no backpressure; consumers must take it in the RESP cycle.
- After a timeout the adder state is undefined. The system must reset the adder before the next request; the arbiter does not drain it.
- Requests that arrive while Busy wait with ReqValid held high. Deasserting ReqValid before acceptance has no effect, and nothing is remembered.

## Timing
- Reset values: state IDLE, Last=NREQ-1 (so requester 0 wins first), count 0, every output 0, operand/result latches 0.
- Reset asserted mid-transaction aborts immediately. No RespValid is produced for the aborted request.
- Accept-to-Go: 1 cycle. Ready-to-RespValid: 1 cycle.
- Minimum accept-to-accept spacing: 3 cycles plus the adder latency.
- A new accept is possible in the cycle after RESP.
- The adder clears AddReady on the edge that samples AddGo. WAIT therefore never sees a stale AddReady left from the previous operation.
- The count width is $clog2(TIMEOUT). It never wraps, because the FSM leaves WAIT at TIMEOUT-1.
- AddA and AddB change only on an accept edge.

## Structure
- Shared package fpadd_arb_pkg holds:
  - typedef enum logic [1:0] ArbState {IDLE, ISSUE, WAIT, RESP}
  - default parameter constants.
- Sub-module rr_picker: purely combinational. Inputs Req[NREQ] and Last. Outputs Grant (one-hot), GrantIdx and Any.
- The FSM, watchdog counter and latches live in fpadd_arbiter.

## Test plan
- Single request: requester 2 sends A=0x3F800000 (1.0), B=0x40000000 (2.0). Expect ReqAccept=4'b0100, AddGo one cycle later, then RespValid with RespId=2, RespData=0x40400000 (3.0), RespError=0.
- Fairness: all four ReqValid held high for 8 transactions. Grant order must be 0,1,2,3,0,1,2,3, and each response carries the correct ID and sum.
- Timeout: model an adder that never raises AddReady. Expect RespValid exactly TIMEOUT+1 cycles after AddGo, with RespError=1 and RespData=0.
- Race at limit: AddReady rises in the same cycle count reaches TIMEOUT-1. Expect RespError=0 and the valid sum.
- Mid-op reset: pull ResetN low during WAIT. All outputs go to 0 immediately with no response. After release, requester 0 wins the first grant.
- Withdrawn request: requester 1 asserts ReqValid only while Busy, then drops it. It never receives ReqAccept and no spurious response appears.
